// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler that shares one 16-bit SPI monarch among NUM_REQ requesters,
// with a post-transaction idle gap and a completion watchdog.
module spi_txn_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  cmd,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     rdy,
    output logic [15:0]            resp,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   clr_err,
    output logic                   spi_wrt,
    output logic [15:0]            spi_wt_data,
    input  logic                   spi_done,
    input  logic [15:0]            spi_rd_data
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Handshake: req is a level held until its one-cycle ack; rdy is a one-cycle
    // pulse on which resp is valid, and resp then holds until the next completion.
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [PW-1:0] pick;
    logic          found;
    logic [WW-1:0] wdog;
    logic [7:0]    gap_cnt;
    logic          done_q;
    logic          done_rise;
    int            idx;

    // Upward search from the pointer with wrap; the pointer slot has top priority.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // done_q resets high so a done level left over from before reset is not an edge.
    assign done_rise = spi_done & ~done_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            winner      <= '0;
            ack         <= '0;
            rdy         <= '0;
            spi_wrt     <= 1'b0;
            resp        <= '0;
            spi_wt_data <= '0;
            timeout_err <= 1'b0;
            wdog        <= '0;
            gap_cnt     <= '0;
            done_q      <= 1'b1;
        end else begin
            ack     <= '0;
            rdy     <= '0;
            spi_wrt <= 1'b0;
            done_q  <= spi_done;
            // A timeout set later in this block overrides a simultaneous clear.
            if (clr_err) timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (found) begin
                        winner      <= pick;
                        spi_wt_data <= cmd[16*int'(pick) +: 16];
                        ack         <= ONE << pick;
                        spi_wrt     <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    ptr   <= (winner == PW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_rise) begin
                        resp    <= spi_rd_data;
                        rdy     <= ONE << winner;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (wdog == WW'(TIMEOUT_CYC-1)) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'(GAP_CYC-1)) state <= IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: a behavioural SPI monarch, requester driver
// and a queue-based scoreboard checking grants and responses.
module tb_spi_txn_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int GAP_CYC     = 8;
    localparam int TIMEOUT_CYC = 2048;
    localparam int W           = NUM_REQ + 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] cmd;
    logic [NUM_REQ-1:0]    ack;
    logic [NUM_REQ-1:0]    rdy;
    logic [15:0]           resp;
    logic                  busy;
    logic                  timeout_err;
    logic                  clr_err;
    logic                  spi_wrt;
    logic [15:0]           spi_wt_data;
    logic                  spi_done;
    logic [15:0]           spi_rd_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int remaining[NUM_REQ];
    int model_stale = 0;
    int model_len   = 20;
    bit model_hang  = 1'b0;

    logic [W-1:0] exp_ack_q[$];
    logic [W-1:0] exp_rdy_q[$];

    spi_txn_arbiter #(
        .NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .ack(ack), .rdy(rdy),
        .resp(resp), .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err),
        .spi_wrt(spi_wrt), .spi_wt_data(spi_wt_data), .spi_done(spi_done),
        .spi_rd_data(spi_rd_data)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] loopback(input logic [15:0] c);
        return (c == 16'h8F00) ? 16'h00D4 : (c ^ 16'h5A5A);
    endfunction

    // ---------------- SPI monarch model ----------------
    // After wrt: keep done at its old level for model_stale cycles, hold it low for
    // model_len cycles, then raise it with the loopback data (never, if model_hang).
    initial begin
        logic [15:0] m_data;
        int          m_cnt;
        bit          m_active;
        spi_done    = 1'b1;
        spi_rd_data = 16'h0000;
        m_data      = 16'h0000;
        m_cnt       = 0;
        m_active    = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_wrt) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_data   = loopback(spi_wt_data);
            end else if (m_active) begin
                m_cnt++;
            end
            if (m_active) begin
                if (m_cnt >= model_stale && m_cnt < model_stale + model_len) begin
                    spi_done = 1'b0;
                end else if (m_cnt >= model_stale + model_len && !model_hang) begin
                    spi_done    = 1'b1;
                    spi_rd_data = m_data;
                    m_active    = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int           rise_cyc;
        bit           prev_done;
        logic [W-1:0] e;
        logic [15:0]  last_cmd;
        rise_cyc  = -1000;
        prev_done = 1'b1;
        last_cmd  = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ack != '0 || spi_wrt) begin
                    check("wrt_with_ack", 32'(spi_wrt), 32'(ack != '0));
                    check("launch_gap", 32'((cyc - rise_cyc) >= GAP_CYC + 2), 32'(1));
                    if (exp_ack_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant: got ack=%b data=%h expected none", ack, spi_wt_data);
                    end else begin
                        e = exp_ack_q.pop_front();
                        check("grant", 32'({ack, spi_wt_data}), 32'(e));
                    end
                    last_cmd = spi_wt_data;
                end
                if (rdy != '0) begin
                    check("rdy_latency", 32'(cyc - rise_cyc), 32'(1));
                    check("wt_data_stable", 32'(spi_wt_data), 32'(last_cmd));
                    if (exp_rdy_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rdy: got rdy=%b resp=%h expected none", rdy, resp);
                    end else begin
                        e = exp_rdy_q.pop_front();
                        check("response", 32'({rdy, resp}), 32'(e));
                    end
                end
            end
            if (spi_done && !prev_done) rise_cyc = cyc;
            prev_done = spi_done;
        end
    end

    // ---------------- requester driver tasks ----------------
    // Each requester holds req until it has seen remaining[i] acks.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack[i] && remaining[i] > 0) remaining[i]--;
            req[i] = (remaining[i] != 0);
        end
    endtask

    task automatic post(input int i, input int n, input logic [15:0] c);
        cmd[16*i +: 16] = c;
        remaining[i]    = n;
        req[i]          = 1'b1;
    endtask

    task automatic expect_txn(input logic [NUM_REQ-1:0] oh, input logic [15:0] c, input logic [15:0] r);
        exp_ack_q.push_back({oh, c});
        exp_rdy_q.push_back({oh, r});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || req != '0) && n < 4000) begin
            tick();
            n++;
        end
        check(name, 32'(busy || req != '0), 32'(0));
        tick();
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (ack == '0 && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(ack != '0), 32'(1));
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
        req = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst     = 1'b1;
        req     = '0;
        cmd     = '0;
        clr_err = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
        tick();
        tick();
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_rdy", 32'(rdy), 32'(0));
        check("rst_wrt", 32'(spi_wrt), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_resp", 32'(resp), 32'(0));
        check("rst_wt_data", 32'(spi_wt_data), 32'(0));
        check("rst_timeout_err", 32'(timeout_err), 32'(0));
        rst = 1'b0;
        tick();

        // Single request: latency, MOSI frame, response, gap length.
        post(0, 1, 16'h8F00);
        expect_txn(3'b001, 16'h8F00, 16'h00D4);
        tick();
        check("t1_ack", 32'(ack), 32'(3'b001));
        check("t1_wrt", 32'(spi_wrt), 32'(1));
        check("t1_mosi", 32'(spi_wt_data), 32'(16'h8F00));
        n = 0;
        while (rdy == '0 && n < 200) begin
            tick();
            n++;
        end
        check("t1_rdy", 32'(rdy), 32'(3'b001));
        check("t1_resp", 32'(resp), 32'(16'h00D4));
        repeat (GAP_CYC-1) tick();
        check("t1_busy_in_gap", 32'(busy), 32'(1));
        tick();
        check("t1_busy_after_gap", 32'(busy), 32'(0));
        wait_idle("t1_idle");

        // All three requesting continuously from reset: order 0,1,2,0,1,2.
        do_reset();
        post(0, 2, 16'h1234);
        post(1, 2, 16'hABCD);
        post(2, 2, 16'h0F0F);
        repeat (2) begin
            expect_txn(3'b001, 16'h1234, 16'h486E);
            expect_txn(3'b010, 16'hABCD, 16'hF197);
            expect_txn(3'b100, 16'h0F0F, 16'h5555);
        end
        wait_idle("t2_idle");

        // Pointer wrap: serve 1 (pointer -> 2), then 0 and 1 together: 0 first.
        post(1, 1, 16'h00FF);
        expect_txn(3'b010, 16'h00FF, 16'h5AA5);
        wait_idle("t3a_idle");
        post(0, 1, 16'hC3C3);
        post(1, 1, 16'h7E01);
        expect_txn(3'b001, 16'hC3C3, 16'h9999);
        expect_txn(3'b010, 16'h7E01, 16'h245B);
        wait_idle("t3b_idle");

        // Stale done: done stays high from the last transaction for 2 cycles past wrt.
        check("t4_done_high_before", 32'(spi_done), 32'(1));
        model_stale = 2;
        post(2, 1, 16'hDEAD);
        expect_txn(3'b100, 16'hDEAD, 16'h84F7);
        wait_idle("t4_idle");
        model_stale = 0;

        // Timeout: monarch never completes.
        model_hang = 1'b1;
        post(0, 1, 16'hBEEF);
        exp_ack_q.push_back({3'b001, 16'hBEEF});
        wait_ack("t5_ack");
        n = 0;
        while (!timeout_err && n < 3000) begin
            tick();
            n++;
        end
        check("t5_timeout_cycles", 32'(n), 32'(TIMEOUT_CYC + 1));
        check("t5_timeout_err", 32'(timeout_err), 32'(1));
        check("t5_resp_held", 32'(resp), 32'(16'h84F7));
        wait_idle("t5a_idle");
        model_hang = 1'b0;
        post(1, 1, 16'h0001);
        expect_txn(3'b010, 16'h0001, 16'h5A5B);
        wait_idle("t5b_idle");
        check("t5_err_sticky", 32'(timeout_err), 32'(1));
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5_err_cleared", 32'(timeout_err), 32'(0));

        // Reset in the middle of WAIT, then requester 2 alone.
        model_len = 300;
        post(0, 1, 16'h4444);
        exp_ack_q.push_back({3'b001, 16'h4444});
        wait_ack("t6_ack");
        repeat (100) tick();
        rst = 1'b1;
        tick();
        check("t6_ack", 32'(ack), 32'(0));
        check("t6_rdy", 32'(rdy), 32'(0));
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_wrt", 32'(spi_wrt), 32'(0));
        check("t6_resp", 32'(resp), 32'(0));
        rst = 1'b0;
        model_len = 20;
        post(2, 1, 16'h2222);
        expect_txn(3'b100, 16'h2222, 16'h7878);
        tick();
        check("t6_grant2", 32'(ack), 32'(3'b100));
        wait_idle("t6_idle");

        repeat (5) tick();
        check("queues_drained", 32'(exp_ack_q.size() + exp_rdy_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
